// File: rtl/sd_cmd_phys.sv
// sd_cmd_phys: SD CMD-line physical layer. It serialises a 48-bit command frame with a
// generated CRC7. If a response is expected, it then releases the line, captures a
// 48-bit response and checks it.
// Ports:
//   SD_clk, RST_L                   clock (rising edge) and async active-low reset
//   cmd_start/cmd_index/cmd_arg     command request from sd_host
//   resp_en                         1 = expect a 48-bit response
//   cmd_in / cmd_out / cmd_oe       CMD line receive, drive value, drive enable
//   busy, done                      transfer in progress, one-cycle completion pulse
//   resp_index, resp_arg            received response fields
//   crc_err, timeout_err            response error flags, valid with done
module sd_cmd_phys #(
  parameter int TIMEOUT = 64,
  parameter int NCR_MIN = 2
) (
  input  logic        SD_clk,
  input  logic        RST_L,
  input  logic        cmd_start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic        resp_en,
  input  logic        cmd_in,
  output logic        cmd_out,
  output logic        cmd_oe,
  output logic        busy,
  output logic        done,
  output logic [5:0]  resp_index,
  output logic [31:0] resp_arg,
  output logic        crc_err,
  output logic        timeout_err
);
  localparam int CW = TIMEOUT > 48 ? $clog2(TIMEOUT) : 6;
  typedef enum logic [2:0] {IDLE, TX, TURN, WAIT, RX, DONE} state_t;
  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [39:0] tx_q, tx_d;
  logic [6:0]  crc_q, crc_d;
  logic [45:0] rx_q, rx_d;
  logic        en_q, en_d;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] arg_q, arg_d;
  logic        cerr_q, cerr_d;
  logic        terr_q, terr_d;
  logic        fb, tx_bit;
  logic [6:0]  crc_step;
  logic [46:0] rx_full;
  // Transmit order: 40 payload bits from the shift register, then the CRC shifted out
  // MSB first, then the end bit.
  assign tx_bit      = cnt_q >= CW'(8) ? tx_q[39] : (cnt_q != '0 ? crc_q[6] : 1'b1);
  // One serial step of the x^7+x^3+1 CRC. It runs over the outgoing bit in TX and
  // over the incoming bit otherwise.
  assign fb          = (state_q == TX ? tx_q[39] : cmd_in) ^ crc_q[6];
  assign crc_step    = {crc_q[5:3], crc_q[2] ^ fb, crc_q[1:0], fb};
  // Response bits 46..0, including the bit being sampled on this edge.
  assign rx_full     = {rx_q, cmd_in};
  assign cmd_oe      = state_q == TX;
  assign cmd_out     = cmd_oe ? tx_bit : 1'b1;
  assign busy        = state_q inside {TX, TURN, WAIT, RX};
  assign done        = state_q == DONE;
  assign resp_index  = idx_q;
  assign resp_arg    = arg_q;
  assign crc_err     = cerr_q;
  assign timeout_err = terr_q;
  always_ff @(posedge SD_clk or negedge RST_L) begin
    if (!RST_L) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tx_q    <= '0;
      crc_q   <= '0;
      rx_q    <= '0;
      en_q    <= 1'b0;
      idx_q   <= '0;
      arg_q   <= '0;
      cerr_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      crc_q   <= crc_d;
      rx_q    <= rx_d;
      en_q    <= en_d;
      idx_q   <= idx_d;
      arg_q   <= arg_d;
      cerr_q  <= cerr_d;
      terr_q  <= terr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    crc_d   = crc_q;
    rx_d    = rx_q;
    en_d    = en_q;
    idx_d   = idx_q;
    arg_d   = arg_q;
    cerr_d  = cerr_q;
    terr_d  = terr_q;
    case (state_q)
      IDLE: if (cmd_start) begin
        state_d = TX;
        cnt_d   = CW'(47);
        tx_d    = {2'b01, cmd_index, cmd_arg};
        crc_d   = '0;
        en_d    = resp_en;
        cerr_d  = 1'b0;
        terr_d  = 1'b0;
      end
      TX: begin
        tx_d    = cnt_q >= CW'(8) ? {tx_q[38:0], 1'b0} : tx_q;
        crc_d   = cnt_q >= CW'(8) ? crc_step : {crc_q[5:0], 1'b0};
        state_d = cnt_q != '0 ? TX : (en_q ? TURN : DONE);
        cnt_d   = cnt_q != '0 ? cnt_q - 1'b1 : CW'(NCR_MIN - 1);
      end
      TURN: begin
        state_d = cnt_q != '0 ? TURN : WAIT;
        cnt_d   = cnt_q != '0 ? cnt_q - 1'b1 : CW'(TIMEOUT - 1);
      end
      WAIT: begin
        // A response start bit is 0, so the CRC state is still zero after it.
        crc_d = '0;
        if (!cmd_in) begin
          state_d = RX;
          cnt_d   = CW'(46);
        end else if (cnt_q == '0) begin
          state_d = DONE;
          terr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RX: begin
        rx_d  = rx_full[45:0];
        crc_d = cnt_q >= CW'(8) ? crc_step : crc_q;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
          cerr_d  = (rx_full[7:1] != crc_q) | rx_full[46] | ~rx_full[0];
          idx_d   = rx_full[45:40];
          arg_d   = rx_full[39:8];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_sd_cmd_phys.sv
// tb_sd_cmd_phys: table-driven self-checking bench for sd_cmd_phys with a transmit-bit scoreboard
module tb_sd_cmd_phys;
  logic        clk = 1'b0;
  logic        RST_L = 1'b0;
  logic        cmd_start = 1'b0;
  logic [5:0]  cmd_index = '0;
  logic [31:0] cmd_arg = '0;
  logic        resp_en = 1'b0;
  logic        cmd_in = 1'b1;
  logic        cmd_out, cmd_oe, busy, done, crc_err, timeout_err;
  logic [5:0]  resp_index;
  logic [31:0] resp_arg;
  int          tests = 0;
  int          fails = 0;
  logic        exp_q[$];
  logic [5:0]  prev_idx = '0;
  logic [31:0] prev_arg = '0;
  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic        en;
    logic [6:0]  tcrc;
    logic [47:0] rsp;
    int          rs;
    logic        mid;
    int          lat;
    logic        cerr;
    logic        terr;
  } vec_t;
  vec_t vec[6];
  sd_cmd_phys dut (
    .SD_clk(clk), .RST_L(RST_L), .cmd_start(cmd_start), .cmd_index(cmd_index),
    .cmd_arg(cmd_arg), .resp_en(resp_en), .cmd_in(cmd_in), .cmd_out(cmd_out),
    .cmd_oe(cmd_oe), .busy(busy), .done(done), .resp_index(resp_index),
    .resp_arg(resp_arg), .crc_err(crc_err), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c = '0;
    for (int k = 39; k >= 0; k--) c = {c[5:0], 1'b0} ^ ((d[k] ^ c[6]) ? 7'h09 : 7'h00);
    return c;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic run(input int i, input int rst_at);
    vec_t v = vec[i];
    logic [47:0] f;
    logic e;
    int n = 1;
    int oe_n = 0;
    logic got = 1'b0;
    f = {2'b01, v.idx, v.arg, v.tcrc, 1'b1};
    for (int b = 47; b >= 0; b--) exp_q.push_back(f[b]);
    @(negedge clk);
    cmd_index = v.idx; cmd_arg = v.arg; resp_en = v.en; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    while (!got && n < 300) begin
      if (n == rst_at) begin
        RST_L = 1'b0;
        #1;
        chk("abort_oe", {31'b0, cmd_oe}, 0);
        chk("abort_out", {31'b0, cmd_out}, 1);
        chk("abort_busy", {31'b0, busy}, 0);
        repeat (3) begin
          @(negedge clk);
          chk("abort_done", {31'b0, done}, 0);
        end
        RST_L = 1'b1;
        exp_q.delete();
        prev_idx = '0;
        prev_arg = '0;
        return;
      end
      if (cmd_oe) begin
        oe_n++;
        if (exp_q.size() == 0) chk("tx_extra_bit", {31'b0, cmd_out}, 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          chk($sformatf("tx_bit[%0d] vec%0d", 48 - oe_n, i), {31'b0, cmd_out}, {31'b0, e});
        end
      end
      cmd_in = (v.rs != 0 && n >= 48 + v.rs && n < 96 + v.rs) ? v.rsp[47 - (n - 48 - v.rs)] : 1'b1;
      if (v.mid && n == 10) begin cmd_start = 1'b1; cmd_index = ~v.idx; end
      if (v.mid && n == 11) cmd_start = 1'b0;
      if (done) got = 1'b1;
      else begin
        chk("busy", {31'b0, busy}, 1);
        @(negedge clk);
        n++;
      end
    end
    chk($sformatf("done_seen vec%0d", i), {31'b0, got}, 1);
    chk("done_busy", {31'b0, busy}, 0);
    if (v.lat != 0) chk($sformatf("latency vec%0d", i), n, v.lat);
    chk($sformatf("oe_cycles vec%0d", i), oe_n, 48);
    chk($sformatf("crc_err vec%0d", i), {31'b0, crc_err}, {31'b0, v.cerr});
    chk($sformatf("timeout_err vec%0d", i), {31'b0, timeout_err}, {31'b0, v.terr});
    if (v.rs != 0) begin prev_idx = v.rsp[45:40]; prev_arg = v.rsp[39:8]; end
    chk($sformatf("resp_index vec%0d", i), {26'b0, resp_index}, {26'b0, prev_idx});
    chk($sformatf("resp_arg vec%0d", i), resp_arg, prev_arg);
    cmd_in = 1'b1;
    @(negedge clk);
    chk("done_pulse", {31'b0, done}, 0);
    chk("idle_busy", {31'b0, busy}, 0);
  endtask
  initial begin
    vec[0] = '{6'd0, 32'h0, 1'b0, 7'h4A, 48'h0, 0, 1'b0, 49, 1'b0, 1'b0};
    vec[1] = '{6'd8, 32'h1AA, 1'b1, 7'h43, 48'h08_00_00_01_AA_13, 5, 1'b0, 0, 1'b0, 1'b0};
    vec[2] = '{6'd8, 32'h1AA, 1'b1, 7'h43, 48'h08_00_00_01_AA_15, 5, 1'b1, 0, 1'b1, 1'b0};
    vec[3] = '{6'd17, 32'h0, 1'b1, 7'h2A, 48'h0, 0, 1'b0, 115, 1'b0, 1'b1};
    vec[4] = '{6'd55, 32'h1234_0000, 1'b1, crc7({2'b01, 6'd55, 32'h1234_0000}),
               {2'b01, 6'd55, 32'h0000_0120, crc7({2'b01, 6'd55, 32'h0000_0120}), 1'b1},
               7, 1'b0, 0, 1'b1, 1'b0};
    vec[5] = '{6'd41, 32'h40FF_8000, 1'b1, crc7({2'b01, 6'd41, 32'h40FF_8000}),
               {2'b00, 6'd55, 32'h0000_0900, crc7({2'b00, 6'd55, 32'h0000_0900}), 1'b0},
               3, 1'b0, 0, 1'b1, 1'b0};
    repeat (2) @(negedge clk);
    chk("rst_out", {31'b0, cmd_out}, 1);
    chk("rst_oe", {31'b0, cmd_oe}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_index", {26'b0, resp_index}, 0);
    chk("rst_arg", resp_arg, 0);
    chk("rst_errs", {30'b0, crc_err, timeout_err}, 0);
    RST_L = 1'b1;
    for (int i = 0; i < 6; i++) run(i, 0);
    run(3, 28);
    run(0, 0);
    @(negedge clk);
    cmd_index = '0; cmd_arg = '0; resp_en = 1'b0; cmd_start = 1'b1;
    for (int n = 1; n <= 51; n++) begin
      @(negedge clk);
      if (n == 49) chk("held_done", {31'b0, done}, 1);
      if (n == 50) chk("held_ignored_in_done", {31'b0, busy}, 0);
      if (n == 51) chk("held_accept_after_done", {31'b0, busy}, 1);
    end
    cmd_start = 1'b0;
    begin
      int k = 0;
      while (!done && k < 100) begin
        @(negedge clk);
        k++;
      end
    end
    chk("held_second_done", {31'b0, done}, 1);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sd_cmd_phys.md
Name: sd_cmd_phys

Overview:
- SD CMD-line physical layer in the SD clock domain; sits directly downstream of sd_host.
- Takes a command request (index, argument, response type) from the host control logic and serialises the 48-bit command frame with a generated CRC7 onto CMD.
- Then releases the line and captures and checks a 48-bit response.
- Reports the response fields, error flags and a one-cycle done pulse back to sd_host.

Parameters:
- TIMEOUT, 64: max SD_clk cycles spent sampling for a response start bit before timeout_err.
- NCR_MIN, 2: line turnaround cycles after the command end bit before response sampling begins.

Ports:
- SD_clk  in  1  SD card clock; all logic on its rising edge.
- RST_L  in  1  asynchronous, active-low reset.
- cmd_start  in  1  request pulse; accepted only while busy=0.
- cmd_index  in  6  command index, sampled at accept.
- cmd_arg  in  32  command argument, sampled at accept.
- resp_en  in  1  1 = expect a 48-bit response; 0 = no response. Sampled at accept.
- cmd_in  in  1  CMD line input from the card.
- cmd_out  out  1  CMD line drive value.
- cmd_oe  out  1  CMD output enable; 1 = host drives the line.
- busy  out  1  high from the cycle after accept until done.
- done  out  1  one-cycle completion pulse.
- resp_index  out  6  received response index bits [45:40].
- resp_arg  out  32  received response bits [39:8].
- crc_err  out  1  response CRC7, transmission bit or end bit mismatch; valid with done.
- timeout_err  out  1  no response start bit within TIMEOUT; valid with done.

Behaviour:
- Reset (async, RST_L=0): state IDLE; cmd_out=1, cmd_oe=0, busy=0, done=0, resp_index=0, resp_arg=0, crc_err=0, timeout_err=0.
- Reset asserted mid-transfer aborts immediately: line is released, no done pulse.
- Frame, MSB first, 48 bits:
  - start bit 0, transmission bit 1 (host) / 0 (card);
  - index[5:0], arg[31:0];
  - CRC7[6:0], end bit 1.
- CRC7: polynomial x^7+x^3+1, initial value 0, computed over the first 40 bits. Computed serially alongside shifting; no lookahead.
- IDLE: on cmd_start=1, latch inputs; clear crc_err and timeout_err; enter TX.
  - Next cycle: busy=1, cmd_oe=1, cmd_out=start bit.
- TX: one bit per cycle for 48 cycles; bit counter runs 47 down to 0.
  - After the end bit: if resp_en=0, go to DONE; else cmd_oe=0, cmd_out=1, go to TURN.
- TURN: NCR_MIN cycles with the line released; cmd_in is ignored. Then go to WAIT.
- WAIT: sample cmd_in every cycle.
  - First cmd_in=0 is response bit 47; go to RX.
  - After TIMEOUT sampled cycles with no 0: timeout_err=1, go to DONE.
- RX: capture the remaining 47 bits into a shift register; run CRC7 over bits 47..8.
  - After bit 0: crc_err=1 if received CRC ≠ computed CRC, or bit 46 ≠ 0, or bit 0 ≠ 1.
  - Load resp_index and resp_arg; go to DONE.
- DONE: done=1 for exactly one cycle, busy=0 in the same cycle; return to IDLE.
  - Error flags and response fields hold until the next accept.
- Latency, no response: done asserts 49 cycles after the accept edge.
- cmd_start while busy=1 or in DONE: ignored, no queueing.
- cmd_start in the cycle after DONE (IDLE) is accepted normally.
- Only the host-side transmission bit is checked; response types other than 48-bit are not supported.

Test Plan:
1. CMD0, arg 0x00000000, resp_en=0 → cmd_out bytes 0x40 00 00 00 00 95 (CRC7=0x4A); cmd_oe=1 for 48 cycles; done at cycle 49; no errors.
2. CMD8, arg 0x000001AA, resp_en=1; card drives 0x08 00 00 01 AA 13 starting 3 cycles after TURN → TX ends with byte 0x87; resp_index=8, resp_arg=0x000001AA, crc_err=0.
3. As test 2, but the card's CRC byte is 0x15 → crc_err=1, done=1, fields still loaded.
4. CMD17, arg 0, resp_en=1, cmd_in held at 1 → TX CRC byte 0x55; timeout_err=1 after exactly TIMEOUT WAIT cycles; done=1.
5. cmd_start pulsed mid-TX with different index → no effect on the frame; busy stays 1.
6. RST_L low at bit 20 of TX → immediate cmd_oe=0, busy=0, no done; a new command after reset transmits correctly.
